// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decode-side inputs, registered EX outputs, front-end enables and counters.
// slave = the stage itself, master = whatever drives decode and observes EX.
interface id_ex_stage_if #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4,
   parameter int CNT_W  = 16
);
   logic              id_valid;
   logic [3:0]        id_opcode;
   logic [REG_AW-1:0] id_op1;
   logic [REG_AW-1:0] id_op2;
   logic [DATA_W-1:0] id_op1_data;
   logic [DATA_W-1:0] id_op2_data;
   logic [DATA_W-1:0] id_imm;
   logic [1:0]        ALUOp;
   logic [1:0]        RegSrc;
   logic              BrOrJmp, Branch, RegWrt, RegSwp, ALUSel0, ALUSel1;
   logic              ReadByte, LoadByte, WBSig, MEMSig;
   logic              br_taken;
   logic              mem_stall;

   logic [1:0]        ex_alu_op;
   logic [1:0]        ex_reg_src;
   logic              ex_reg_wrt, ex_reg_swp, ex_alu_sel0, ex_alu_sel1, ex_read_byte;
   logic              ex_load_byte, ex_mem_rd, ex_mem_wrt, ex_wb, ex_mem;
   logic              ex_valid;
   logic [REG_AW-1:0] ex_rd;
   logic [DATA_W-1:0] ex_op1_data;
   logic [DATA_W-1:0] ex_op2_data;
   logic [DATA_W-1:0] ex_imm;
   logic              pc_write, ifid_write, ifid_flush;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   modport slave (
      input  id_valid, id_opcode, id_op1, id_op2, id_op1_data, id_op2_data, id_imm,
             ALUOp, RegSrc, BrOrJmp, Branch, RegWrt, RegSwp, ALUSel0, ALUSel1,
             ReadByte, LoadByte, WBSig, MEMSig, br_taken, mem_stall,
      output ex_alu_op, ex_reg_src, ex_reg_wrt, ex_reg_swp, ex_alu_sel0, ex_alu_sel1,
             ex_read_byte, ex_load_byte, ex_mem_rd, ex_mem_wrt, ex_wb, ex_mem,
             ex_valid, ex_rd, ex_op1_data, ex_op2_data, ex_imm,
             pc_write, ifid_write, ifid_flush, stall_cnt, flush_cnt
   );

   modport master (
      output id_valid, id_opcode, id_op1, id_op2, id_op1_data, id_op2_data, id_imm,
             ALUOp, RegSrc, BrOrJmp, Branch, RegWrt, RegSwp, ALUSel0, ALUSel1,
             ReadByte, LoadByte, WBSig, MEMSig, br_taken, mem_stall,
      input  ex_alu_op, ex_reg_src, ex_reg_wrt, ex_reg_swp, ex_alu_sel0, ex_alu_sel1,
             ex_read_byte, ex_load_byte, ex_mem_rd, ex_mem_wrt, ex_wb, ex_mem,
             ex_valid, ex_rd, ex_op1_data, ex_op2_data, ex_imm,
             pc_write, ifid_write, ifid_flush, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX register with load-use bubble insertion and branch/jump flush; 1-cycle latency ID->EX.
// mem_stall freezes the whole stage and the front end; load-use stalls the front end one cycle.
module id_ex_stage #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4,
   parameter int CNT_W  = 16
) (
   input logic           clk,
   input logic           rst_n,
   id_ex_stage_if.slave  bus
);
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic [1:0]        alu_op;
      logic [1:0]        reg_src;
      logic              reg_wrt;
      logic              reg_swp;
      logic              alu_sel0;
      logic              alu_sel1;
      logic              read_byte;
      logic              load_byte;
      logic              mem_rd;
      logic              mem_wrt;
      logic              wb;
      logic              mem;
      logic [DATA_W-1:0] op1_data;
      logic [DATA_W-1:0] op2_data;
      logic [DATA_W-1:0] imm;
   } ex_t;

   ex_t              ex_q, ex_d, id_pkt;
   logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
   logic             is_ld, is_st, is_alu, is_real;
   logic             luh, fl;
   logic             pc_write, ifid_write, ifid_flush;
   logic             unused_ok;

   assign unused_ok = ^{bus.RegWrt, bus.WBSig, bus.MEMSig};

   // Anything that is not a clean load/store/ALU op becomes an all-zero bubble,
   // which also scrubs don't-care bits coming out of decode.
   always_comb begin
      is_ld   = (bus.id_opcode == 4'b1010) || (bus.id_opcode == 4'b1100);
      is_st   = (bus.id_opcode == 4'b1011) || (bus.id_opcode == 4'b1101);
      is_alu  = (bus.id_opcode == 4'b1111) || (bus.id_opcode == 4'b1000) ||
                (bus.id_opcode == 4'b1001);
      is_real = bus.id_valid && (is_ld || is_st || is_alu);
      id_pkt  = '0;
      if (is_real) begin
         id_pkt.valid     = 1'b1;
         id_pkt.rd        = bus.id_op1;
         id_pkt.alu_op    = bus.ALUOp;
         id_pkt.reg_src   = bus.RegSrc;
         id_pkt.reg_wrt   = is_ld || is_alu;
         id_pkt.reg_swp   = bus.RegSwp;
         id_pkt.alu_sel0  = bus.ALUSel0;
         id_pkt.alu_sel1  = bus.ALUSel1;
         id_pkt.read_byte = bus.ReadByte;
         id_pkt.load_byte = bus.LoadByte;
         id_pkt.mem_rd    = is_ld;
         id_pkt.mem_wrt   = is_st;
         id_pkt.wb        = is_ld || is_alu;
         id_pkt.mem       = is_ld || is_st;
         id_pkt.op1_data  = bus.id_op1_data;
         id_pkt.op2_data  = bus.id_op2_data;
         id_pkt.imm       = bus.id_imm;
      end
   end

   assign luh = ex_q.valid && ex_q.mem_rd && bus.id_valid &&
                ((ex_q.rd == bus.id_op1) || (ex_q.rd == bus.id_op2));
   assign fl  = bus.id_valid && bus.Branch && (bus.BrOrJmp || bus.br_taken);

   always_comb begin
      ex_d       = ex_q;
      stall_d    = stall_q;
      flush_d    = flush_q;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b0;
      if (bus.mem_stall) begin
         ex_d = ex_q;
      end else if (luh) begin
         // A flush coinciding with the stall is dropped; IF/ID still holds it next cycle.
         ex_d    = '0;
         stall_d = (stall_q == {CNT_W{1'b1}}) ? stall_q : stall_q + CNT_W'(1);
      end else begin
         ex_d       = id_pkt;
         pc_write   = 1'b1;
         ifid_write = 1'b1;
         if (fl) begin
            ifid_flush = 1'b1;
            flush_d    = (flush_q == {CNT_W{1'b1}}) ? flush_q : flush_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q    <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         ex_q    <= ex_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign bus.ex_valid     = ex_q.valid;
   assign bus.ex_rd        = ex_q.rd;
   assign bus.ex_alu_op    = ex_q.alu_op;
   assign bus.ex_reg_src   = ex_q.reg_src;
   assign bus.ex_reg_wrt   = ex_q.reg_wrt;
   assign bus.ex_reg_swp   = ex_q.reg_swp;
   assign bus.ex_alu_sel0  = ex_q.alu_sel0;
   assign bus.ex_alu_sel1  = ex_q.alu_sel1;
   assign bus.ex_read_byte = ex_q.read_byte;
   assign bus.ex_load_byte = ex_q.load_byte;
   assign bus.ex_mem_rd    = ex_q.mem_rd;
   assign bus.ex_mem_wrt   = ex_q.mem_wrt;
   assign bus.ex_wb        = ex_q.wb;
   assign bus.ex_mem       = ex_q.mem;
   assign bus.ex_op1_data  = ex_q.op1_data;
   assign bus.ex_op2_data  = ex_q.op2_data;
   assign bus.ex_imm       = ex_q.imm;
   assign bus.pc_write     = pc_write;
   assign bus.ifid_write   = ifid_write;
   assign bus.ifid_flush   = ifid_flush;
   assign bus.stall_cnt    = stall_q;
   assign bus.flush_cnt    = flush_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus hand sequences for stalls, flush and reset.
// A second instance with 2-bit counters exercises saturation within a short run.
module tb_id_ex_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   id_ex_stage_if #(.DATA_W(16), .REG_AW(4), .CNT_W(16)) bus ();
   id_ex_stage_if #(.DATA_W(16), .REG_AW(4), .CNT_W(2))  sbus ();

   id_ex_stage #(.DATA_W(16), .REG_AW(4), .CNT_W(16)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
   id_ex_stage #(.DATA_W(16), .REG_AW(4), .CNT_W(2))  dut_s (.clk(clk), .rst_n(rst_n), .bus(sbus));

   // bits = {BrOrJmp, Branch, RegWrt, RegSwp, ALUSel0, ALUSel1, ReadByte, LoadByte}
   // e_flags = {reg_wrt, mem_rd, mem_wrt, wb, mem, alu_sel1, alu_sel0, load_byte, reg_swp, read_byte}
   typedef struct {
      logic        vld;
      logic [3:0]  opc;
      logic [3:0]  op1;
      logic [3:0]  op2;
      logic [15:0] d1;
      logic [15:0] d2;
      logic [15:0] imm;
      logic [1:0]  aluop;
      logic [1:0]  regsrc;
      logic [7:0]  bits;
      logic        brt;
      logic        e_pcw;
      logic        e_fl;
      logic        e_valid;
      logic [3:0]  e_rd;
      logic [1:0]  e_aluop;
      logic [1:0]  e_regsrc;
      logic [9:0]  e_flags;
      logic [15:0] e_d1;
      logic [15:0] e_d2;
      logic [15:0] e_imm;
      logic [15:0] e_stall;
      logic [15:0] e_flush;
   } vec_t;

   localparam int NV = 10;
   vec_t vt [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h @%0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      bus.id_valid    = v.vld;
      bus.id_opcode   = v.opc;
      bus.id_op1      = v.op1;
      bus.id_op2      = v.op2;
      bus.id_op1_data = v.d1;
      bus.id_op2_data = v.d2;
      bus.id_imm      = v.imm;
      bus.ALUOp       = v.aluop;
      bus.RegSrc      = v.regsrc;
      bus.BrOrJmp     = v.bits[7];
      bus.Branch      = v.bits[6];
      bus.RegWrt      = v.bits[5];
      bus.RegSwp      = v.bits[4];
      bus.ALUSel0     = v.bits[3];
      bus.ALUSel1     = v.bits[2];
      bus.ReadByte    = v.bits[1];
      bus.LoadByte    = v.bits[0];
      bus.WBSig       = v.bits[5];
      bus.MEMSig      = v.bits[5];
      bus.br_taken    = v.brt;
   endtask

   task automatic set_id(input logic vld, input logic [3:0] opc, input logic [3:0] op1,
                         input logic [3:0] op2, input logic [7:0] bits, input logic [1:0] alu);
      vec_t v;
      v        = vt[0];
      v.vld    = vld;
      v.opc    = opc;
      v.op1    = op1;
      v.op2    = op2;
      v.d1     = 16'hC0DE;
      v.d2     = 16'hBEEF;
      v.imm    = 16'h0042;
      v.aluop  = alu;
      v.regsrc = 2'b00;
      v.bits   = bits;
      v.brt    = 1'b0;
      drive(v);
   endtask

   task automatic sdrive(input logic [3:0] opc, input logic [3:0] op1, input logic [3:0] op2,
                         input logic [7:0] bits);
      sbus.id_valid  = 1'b1;
      sbus.id_opcode = opc;
      sbus.id_op1    = op1;
      sbus.id_op2    = op2;
      sbus.BrOrJmp   = bits[7];
      sbus.Branch    = bits[6];
   endtask

   initial begin
      vt[0] = '{1'b1, 4'b1000, 4'd2, 4'd5, 16'h1111, 16'h2222, 16'h0003, 2'b00, 2'b01, 8'b0000_0100, 1'b0,
                1'b1, 1'b0, 1'b1, 4'd2, 2'd0, 2'd1, 10'b1001010000, 16'h1111, 16'h2222, 16'h0003, 16'd0, 16'd0};
      vt[1] = '{1'b1, 4'b1100, 4'd3, 4'd0, 16'hAAAA, 16'hBBBB, 16'h0004, 2'b10, 2'b00, 8'b0000_0001, 1'b0,
                1'b1, 1'b0, 1'b1, 4'd3, 2'd2, 2'd0, 10'b1101100100, 16'hAAAA, 16'hBBBB, 16'h0004, 16'd0, 16'd0};
      vt[2] = '{1'b1, 4'b1111, 4'd4, 4'd3, 16'h0101, 16'h0202, 16'h0000, 2'b01, 2'b10, 8'b0000_1000, 1'b0,
                1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 2'd0, 10'b0, 16'h0, 16'h0, 16'h0, 16'd1, 16'd0};
      vt[3] = '{1'b1, 4'b1111, 4'd4, 4'd3, 16'h0101, 16'h0202, 16'h0000, 2'b01, 2'b10, 8'b0000_1000, 1'b0,
                1'b1, 1'b0, 1'b1, 4'd4, 2'd1, 2'd2, 10'b1001001000, 16'h0101, 16'h0202, 16'h0000, 16'd1, 16'd0};
      vt[4] = '{1'b1, 4'b0110, 4'd0, 4'd1, 16'hFFFF, 16'hFFFF, 16'h00FF, 2'b11, 2'b11, 8'b0110_1111, 1'b1,
                1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 2'd0, 10'b0, 16'h0, 16'h0, 16'h0, 16'd1, 16'd1};
      vt[5] = '{1'b1, 4'b0001, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 8'b1100_0000, 1'b0,
                1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 2'd0, 10'b0, 16'h0, 16'h0, 16'h0, 16'd1, 16'd2};
      vt[6] = '{1'b1, 4'b1011, 4'd6, 4'd7, 16'h1234, 16'h5678, 16'h0010, 2'b00, 2'b00, 8'b0011_0010, 1'b1,
                1'b1, 1'b0, 1'b1, 4'd6, 2'd0, 2'd0, 10'b0010100011, 16'h1234, 16'h5678, 16'h0010, 16'd1, 16'd2};
      vt[7] = '{1'b0, 4'b1000, 4'd9, 4'd9, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2'b11, 2'b11, 8'b1111_1111, 1'b1,
                1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 2'd0, 10'b0, 16'h0, 16'h0, 16'h0, 16'd1, 16'd2};
      vt[8] = '{1'b1, 4'b0011, 4'd9, 4'd9, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2'b11, 2'b11, 8'b0011_1111, 1'b0,
                1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 2'd0, 10'b0, 16'h0, 16'h0, 16'h0, 16'd1, 16'd2};
      vt[9] = '{1'b1, 4'b0110, 4'd1, 4'd2, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 8'b0100_0000, 1'b0,
                1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 2'd0, 10'b0, 16'h0, 16'h0, 16'h0, 16'd1, 16'd2};

      set_id(1'b0, 4'b0000, 4'd0, 4'd0, 8'h00, 2'b00);
      bus.mem_stall = 1'b0;
      sbus.id_valid = 1'b0; sbus.id_opcode = 4'd0; sbus.id_op1 = 4'd0; sbus.id_op2 = 4'd0;
      sbus.id_op1_data = 16'd0; sbus.id_op2_data = 16'd0; sbus.id_imm = 16'd0;
      sbus.ALUOp = 2'b00; sbus.RegSrc = 2'b00; sbus.BrOrJmp = 1'b0; sbus.Branch = 1'b0;
      sbus.RegWrt = 1'b0; sbus.RegSwp = 1'b0; sbus.ALUSel0 = 1'b0; sbus.ALUSel1 = 1'b0;
      sbus.ReadByte = 1'b0; sbus.LoadByte = 1'b0; sbus.WBSig = 1'b0; sbus.MEMSig = 1'b0;
      sbus.br_taken = 1'b0; sbus.mem_stall = 1'b0;

      #12;
      chk("rst.ex_valid", bus.ex_valid, 0);
      chk("rst.stall_cnt", bus.stall_cnt, 0);
      chk("rst.flush_cnt", bus.flush_cnt, 0);
      chk("rst.pc_write", bus.pc_write, 1);
      chk("rst.ifid_write", bus.ifid_write, 1);
      #9 rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(vt[i]);
         #1;
         chk($sformatf("v%0d.pc_write", i), bus.pc_write, vt[i].e_pcw);
         chk($sformatf("v%0d.ifid_write", i), bus.ifid_write, vt[i].e_pcw);
         chk($sformatf("v%0d.ifid_flush", i), bus.ifid_flush, vt[i].e_fl);
         tick();
         chk($sformatf("v%0d.ex_valid", i), bus.ex_valid, vt[i].e_valid);
         if (vt[i].e_valid) chk($sformatf("v%0d.ex_rd", i), bus.ex_rd, vt[i].e_rd);
         chk($sformatf("v%0d.ex_alu_op", i), bus.ex_alu_op, vt[i].e_aluop);
         chk($sformatf("v%0d.ex_reg_src", i), bus.ex_reg_src, vt[i].e_regsrc);
         chk($sformatf("v%0d.flags", i),
             {bus.ex_reg_wrt, bus.ex_mem_rd, bus.ex_mem_wrt, bus.ex_wb, bus.ex_mem, bus.ex_alu_sel1,
              bus.ex_alu_sel0, bus.ex_load_byte, bus.ex_reg_swp, bus.ex_read_byte}, vt[i].e_flags);
         chk($sformatf("v%0d.ex_op1_data", i), bus.ex_op1_data, vt[i].e_d1);
         chk($sformatf("v%0d.ex_op2_data", i), bus.ex_op2_data, vt[i].e_d2);
         chk($sformatf("v%0d.ex_imm", i), bus.ex_imm, vt[i].e_imm);
         chk($sformatf("v%0d.stall_cnt", i), bus.stall_cnt, vt[i].e_stall);
         chk($sformatf("v%0d.flush_cnt", i), bus.flush_cnt, vt[i].e_flush);
      end

      // load-use coinciding with a jump: flush waits for the stall cycle to pass
      set_id(1'b1, 4'b1010, 4'd8, 4'd0, 8'h00, 2'b00);
      tick();
      chk("luhfl.load_mem_rd", bus.ex_mem_rd, 1);
      chk("luhfl.load_rd", bus.ex_rd, 8);
      set_id(1'b1, 4'b0001, 4'd8, 4'd8, 8'b1100_0000, 2'b00);
      #1;
      chk("luhfl.flush_suppressed", bus.ifid_flush, 0);
      chk("luhfl.pc_write", bus.pc_write, 0);
      tick();
      chk("luhfl.bubble", bus.ex_valid, 0);
      chk("luhfl.stall_cnt", bus.stall_cnt, 2);
      chk("luhfl.flush_cnt_hold", bus.flush_cnt, 2);
      #1;
      chk("luhfl.flush_retry", bus.ifid_flush, 1);
      chk("luhfl.pc_write_retry", bus.pc_write, 1);
      tick();
      chk("luhfl.flush_cnt", bus.flush_cnt, 3);

      // mem_stall freezes EX and the front end, even against a pending jump
      set_id(1'b1, 4'b1001, 4'd5, 4'd6, 8'h00, 2'b11);
      tick();
      chk("ms.latched_alu_op", bus.ex_alu_op, 3);
      bus.mem_stall = 1'b1;
      set_id(1'b1, 4'b0001, 4'd0, 4'd0, 8'b1100_0000, 2'b00);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("ms%0d.pc_write", c), bus.pc_write, 0);
         chk($sformatf("ms%0d.ifid_write", c), bus.ifid_write, 0);
         chk($sformatf("ms%0d.ifid_flush", c), bus.ifid_flush, 0);
         tick();
         chk($sformatf("ms%0d.ex_alu_op", c), bus.ex_alu_op, 3);
         chk($sformatf("ms%0d.ex_rd", c), bus.ex_rd, 5);
         chk($sformatf("ms%0d.ex_valid", c), bus.ex_valid, 1);
         chk($sformatf("ms%0d.stall_cnt", c), bus.stall_cnt, 2);
         chk($sformatf("ms%0d.flush_cnt", c), bus.flush_cnt, 3);
      end
      bus.mem_stall = 1'b0;
      #1;
      chk("ms.release_flush", bus.ifid_flush, 1);
      chk("ms.release_pc_write", bus.pc_write, 1);
      tick();
      chk("ms.release_bubble", bus.ex_valid, 0);
      chk("ms.release_flush_cnt", bus.flush_cnt, 4);

      // mem_stall outranks a load-use hazard; the hazard resolves after release
      set_id(1'b1, 4'b1100, 4'd7, 4'd0, 8'h00, 2'b00);
      tick();
      bus.mem_stall = 1'b1;
      set_id(1'b1, 4'b1111, 4'd1, 4'd7, 8'h00, 2'b01);
      tick();
      chk("msluh.stall_cnt_frozen", bus.stall_cnt, 2);
      chk("msluh.mem_rd_held", bus.ex_mem_rd, 1);
      bus.mem_stall = 1'b0;
      #1;
      chk("msluh.pc_write", bus.pc_write, 0);
      tick();
      chk("msluh.bubble", bus.ex_valid, 0);
      chk("msluh.stall_cnt", bus.stall_cnt, 3);
      #1;
      chk("msluh.pc_write_after", bus.pc_write, 1);
      tick();
      chk("msluh.dep_valid", bus.ex_valid, 1);
      chk("msluh.dep_rd", bus.ex_rd, 1);
      chk("msluh.dep_alu_op", bus.ex_alu_op, 1);

      // asynchronous reset in the middle of a hold
      bus.mem_stall = 1'b1;
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("arst.ex_valid", bus.ex_valid, 0);
      chk("arst.ex_alu_op", bus.ex_alu_op, 0);
      chk("arst.ex_reg_wrt", bus.ex_reg_wrt, 0);
      chk("arst.ex_op1_data", bus.ex_op1_data, 0);
      chk("arst.stall_cnt", bus.stall_cnt, 0);
      chk("arst.flush_cnt", bus.flush_cnt, 0);
      bus.mem_stall = 1'b0;
      #1;
      chk("arst.pc_write", bus.pc_write, 1);
      chk("arst.ifid_write", bus.ifid_write, 1);
      #1 rst_n = 1'b1;
      tick();
      chk("arst.recapture_valid", bus.ex_valid, 1);
      chk("arst.recapture_rd", bus.ex_rd, 1);
      chk("arst.recapture_data", bus.ex_op1_data, 16'hC0DE);
      set_id(1'b0, 4'b0000, 4'd0, 4'd0, 8'h00, 2'b00);

      // counter saturation on the narrow-counter instance
      for (int k = 0; k < 4; k++) begin
         sdrive(4'b1100, 4'd1, 4'd0, 8'h00);
         tick();
         sdrive(4'b1111, 4'd2, 4'd1, 8'h00);
         tick();
         tick();
         chk($sformatf("sat.stall%0d", k), sbus.stall_cnt, (k < 3) ? k + 1 : 3);
      end
      for (int k = 0; k < 4; k++) begin
         sdrive(4'b0001, 4'd0, 4'd0, 8'b1100_0000);
         tick();
         chk($sformatf("sat.flush%0d", k), sbus.flush_cnt, (k < 3) ? k + 1 : 3);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage for the 4-bit-opcode pipelined core. It sits directly downstream of the decode control unit and captures that unit's control bundle, the register operands and the immediate into the ID/EX register. It also detects load-use hazards, stalls the front end and inserts bubbles. It raises the IF/ID flush for taken branches and jumps, and keeps saturating stall and flush counters.

## Interface
- DATA_W, 16, operand/immediate width
- REG_AW, 4, register-field width (16 registers)
- CNT_W, 16, performance counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_opcode  in  4  instruction opcode
- id_op1, id_op2  in  REG_AW  register fields; op1 is the destination
- id_op1_data, id_op2_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- ALUOp, RegSrc  in  2  control bundle from decode
- BrOrJmp, Branch, RegWrt, RegSwp, ALUSel0, ALUSel1, ReadByte, LoadByte, WBSig, MEMSig  in  1  control bundle from decode
- br_taken  in  1  ID comparator result for the current conditional branch
- mem_stall  in  1  downstream hold request
- ex_alu_op, ex_reg_src  out  2  registered
- ex_reg_wrt, ex_reg_swp, ex_alu_sel0, ex_alu_sel1, ex_read_byte, ex_load_byte, ex_mem_rd, ex_mem_wrt, ex_wb, ex_mem  out  1  registered
- ex_valid  out  1  registered
- ex_rd  out  REG_AW  registered destination
- ex_op1_data, ex_op2_data, ex_imm  out  DATA_W  registered
- pc_write, ifid_write  out  1  combinational front-end enables
- ifid_flush  out  1  combinational
- stall_cnt, flush_cnt  out  CNT_W  registered, saturating

## Operation
- Clean qualifiers:
  - is_ld = opcode 1010 or 1100.
  - is_st = opcode 1011 or 1101.
  - is_alu = opcode 1111, 1000 or 1001.
  - real = id_valid & (is_ld | is_st | is_alu).
- Branches and jumps (Branch=1) and unknown opcodes complete in ID. They enter EX as a bubble.
- Memory and write-back qualifiers are derived only from the opcode, never from decode don't-care bits:
  - ex_mem_rd ← is_ld; ex_mem_wrt ← is_st.
  - ex_wb ← is_ld | is_alu; ex_reg_wrt ← is_ld | is_alu.
  - ex_mem ← is_ld | is_st.
- The remaining bundle bits are captured from the input when real=1 and forced to 0 otherwise. This masks every x coming from decode.
- Load-use hazard: luh = ex_valid & ex_mem_rd & id_valid & (ex_rd == id_op1 | ex_rd == id_op2). Both fields are compared conservatively, for every opcode.
- Jump/branch flush request: fl = id_valid & Branch & (BrOrJmp | br_taken).
- Per-cycle priority:
  1. mem_stall=1:
     - All ex_* hold.
     - pc_write=0, ifid_write=0, ifid_flush=0.
     - Neither counter moves.
  2. luh=1:
     - pc_write=0, ifid_write=0, ifid_flush=0.
     - ID/EX loads a bubble (all ex_* bits 0, ex_valid=0, data fields 0).
     - stall_cnt +1.
     - A coincident fl is suppressed and re-evaluated next cycle.
  3. Otherwise:
     - pc_write=1, ifid_write=1.
     - ID/EX loads the ID contents (bubble if real=0).
     - If fl=1: ifid_flush=1 and flush_cnt +1.
- ex_valid ← real. ex_rd ← id_op1.
- ex_op1_data, ex_op2_data and ex_imm are captured from the inputs when real=1, else 0.
- Counters saturate at 2^CNT_W−1. They never wrap.

## Timing
- Reset (async, rst_n=0) immediately drives every registered output to 0, counters included. The combinational outputs then follow their equations with ex_valid=0: pc_write=1, ifid_write=1.
- A reset asserted mid-stall discards the held contents. The first edge after deassertion captures normally.
- Latency: an instruction present in ID at edge N appears on ex_* after edge N.
- A load-use stall lasts exactly one cycle, because the bubble clears ex_mem_rd. The dependent instruction advances on the following edge.
- pc_write, ifid_write and ifid_flush are valid in the same cycle as their inputs. They are sampled by IF at the same edge.
- mem_stall may last any number of cycles. Release resumes the priority evaluation with the held EX contents.

## Test plan
- Reset mid-stream: assert rst_n=0 asynchronously between edges with ex_valid=1 → all ex_*, stall_cnt and flush_cnt read 0 before the next edge; pc_write=1.
- Opcode 1000, op1=2, id_valid=1, no hazard → after one edge: ex_alu_op=00, ex_alu_sel1=1, ex_reg_src=01, ex_reg_wrt=1, ex_mem_rd=0, ex_rd=2, ex_valid=1.
- Opcode 1100 with op1=3, then opcode 1111 with op2=3:
  - Cycle 2 shows pc_write=0, ifid_write=0, and the next edge inserts a bubble (ex_valid=0).
  - stall_cnt=1.
  - The 1111 instruction reaches EX one edge later.
- Opcode 0110 with br_taken=1 → ifid_flush=1 in that cycle; the next edge loads a bubble; flush_cnt=1. Opcode 0001 with br_taken=0 → ifid_flush=1.
- mem_stall=1 for 3 cycles after the 1001 instruction is latched → ex_alu_op=11 stays stable; pc_write=0; counters unchanged; the pipeline resumes on release.
- Preload stall_cnt to 0xFFFF by repeated load-use stalls (or force it) → the next stall leaves it at 0xFFFF.
